alu_rr_sched: RTL and testbench

//  Shares one 4-bit ALU instance among NUM_REQ requesters using round-robin arbitration.

---
 rtl/alu_rr_sched.sv | 200 ++++++++++++++++++++
 tb/tb_alu_rr_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_sched
// Description : Round-robin scheduler that shares one 4-bit ALU among
//               NUM_REQ requesters. One operation is in flight at a time:
//               accept (IDLE) -> compute (EXEC) -> respond (RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_sched #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_opc,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [2:0]      opc_q, opc_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [3:0]      res_q, res_d;
  logic            c_q, c_d;
  logic            z_q, z_d;
  logic            v_q, v_d;

  logic [2:0]      opc_arr [NUM_REQ];
  logic [3:0]      a_arr   [NUM_REQ];
  logic [3:0]      b_arr   [NUM_REQ];
  logic [ID_W-1:0] grant;
  logic            any_valid;

  logic [4:0]      sum5;
  logic [4:0]      dif5;
  logic [3:0]      alu_res;
  logic            alu_c;
  logic            alu_z;
  logic            alu_v;

  // Split the flat payload buses into per-requester fields.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opc_arr[gi] = req_opc[3*gi +: 3];
    assign a_arr[gi]   = req_a[4*gi +: 4];
    assign b_arr[gi]   = req_b[4*gi +: 4];
  end

  // First valid requester found scanning ptr, ptr+1, ... modulo NUM_REQ.
  // The scan runs from the farthest position down so the nearest one wins.
  // ptr is always < NUM_REQ, so one conditional subtraction keeps the index
  // in range even for non-power-of-2 NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0]    p);
    logic [ID_W:0]   s;
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, p} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
      if (v[s[ID_W-1:0]]) pick = s[ID_W-1:0];
    end
    return pick;
  endfunction

  assign grant     = rr_pick(req_valid, ptr_q);
  assign any_valid = |req_valid;

  // ALU, fed only from the operand registers. For subtraction the carry
  // flag is the unsigned borrow (set when A < B).
  always_comb begin
    sum5    = {1'b0, a_q} + {1'b0, b_q};
    dif5    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = 4'h0;
    alu_c   = 1'b0;
    alu_z   = 1'b0;
    alu_v   = 1'b0;
    case (opc_q)
      3'b000: begin
        alu_res = sum5[3:0];
        alu_c   = sum5[4];
        alu_z   = (sum5[3:0] == 4'h0);
        alu_v   = (a_q[3] == b_q[3]) && (sum5[3] != a_q[3]);
      end
      3'b001: begin
        alu_res = dif5[3:0];
        alu_c   = dif5[4];
        alu_z   = (dif5[3:0] == 4'h0);
        alu_v   = (a_q[3] != b_q[3]) && (dif5[3] != a_q[3]);
      end
      3'b010:  alu_res = ~a_q;
      3'b011:  alu_res = a_q & b_q;
      3'b100:  alu_res = a_q | b_q;
      3'b101:  alu_res = a_q ^ b_q;
      3'b110:  alu_res = {3'b000, ($signed(a_q) < $signed(b_q))};
      default: alu_res = {3'b000, (a_q == b_q)};
    endcase
  end

  // Next-state logic, grant handshake and operand/result capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    opc_d     = opc_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    rid_d     = rid_q;
    res_d     = res_q;
    c_d       = c_q;
    z_d       = z_q;
    v_d       = v_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_ready = NUM_REQ'(1) << grant;
          opc_d     = opc_arr[grant];
          a_d       = a_arr[grant];
          b_d       = b_arr[grant];
          id_d      = grant;
          ptr_d     = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        rid_d   = id_q;
        res_d   = alu_res;
        c_d     = alu_c;
        z_d     = alu_z;
        v_d     = alu_v;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // No handshake may complete while reset is asserted.
    if (!rst_n) req_ready = '0;
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      rid_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign rsp_id       = rid_q;
  assign rsp_result   = res_q;
  assign rsp_carry    = c_q;
  assign rsp_zero     = z_q;
  assign rsp_overflow = v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_sched
// Description : Self-checking bench for alu_rr_sched (NUM_REQ=4 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // NUM_REQ = 4 instance
  logic        rst4_n;
  logic [3:0]  v4, rdy4;
  logic [11:0] opc4;
  logic [15:0] a4, b4;
  logic        rspr4, rspv4;
  logic [1:0]  id4;
  logic [3:0]  res4;
  logic        c4, z4, o4, busy4;

  // NUM_REQ = 3 instance
  logic        rst3_n;
  logic [2:0]  v3, rdy3;
  logic [8:0]  opc3;
  logic [11:0] a3, b3;
  logic        rspr3, rspv3;
  logic [1:0]  id3;
  logic [3:0]  res3;
  logic        c3, z3, o3, busy3;

  alu_rr_sched #(.NUM_REQ(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .req_valid(v4), .req_ready(rdy4),
    .req_opc(opc4), .req_a(a4), .req_b(b4), .rsp_valid(rspv4),
    .rsp_ready(rspr4), .rsp_id(id4), .rsp_result(res4), .rsp_carry(c4),
    .rsp_zero(z4), .rsp_overflow(o4), .busy(busy4)
  );

  alu_rr_sched #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3),
    .req_opc(opc3), .req_a(a3), .req_b(b3), .rsp_valid(rspv3),
    .rsp_ready(rspr3), .rsp_id(id3), .rsp_result(res3), .rsp_carry(c3),
    .rsp_zero(z3), .rsp_overflow(o3), .busy(busy3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int ptr4 = 0;
  int ptr3 = 0;

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic int rr_pick(input int mask, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (((mask >> ((ptr + k) % n)) & 1) == 1) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic model_alu(input int opc, input int a, input int b,
                           output int r, output int c, output int z, output int v);
    int s;
    r = 0; c = 0; z = 0; v = 0;
    case (opc)
      0: begin
        s = a + b; r = s % 16; c = (s > 15) ? 1 : 0; z = (r == 0) ? 1 : 0;
        s = sx(a) + sx(b); v = (s > 7 || s < -8) ? 1 : 0;
      end
      1: begin
        s = a - b; r = (s + 16) % 16; c = (a < b) ? 1 : 0; z = (r == 0) ? 1 : 0;
        s = sx(a) - sx(b); v = (s > 7 || s < -8) ? 1 : 0;
      end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (sx(a) < sx(b)) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
  endtask

  // ---------------- transaction helpers ----------------
  // Called at negedge+1 with the DUT idle; returns at negedge+1, idle again.
  task automatic op4(input logic [3:0] mask, input logic [11:0] opcs,
                     input logic [15:0] as, input logic [15:0] bs,
                     input int eg, input int er, input int ec, input int ez,
                     input int ev, input string tag);
    v4 = mask; opc4 = opcs; a4 = as; b4 = bs; rspr4 = 1'b1;
    #1;
    chk({tag, " idle busy"}, int'(busy4), 0);
    chk({tag, " ready"}, int'(rdy4), (eg < 0) ? 0 : (1 << eg));
    @(negedge clk); #1;
    if (eg < 0) begin
      chk({tag, " no-grant busy"}, int'(busy4), 0);
      v4 = '0;
      return;
    end
    ptr4 = (eg + 1) % 4;
    v4 = '0;
    chk({tag, " exec busy"}, int'(busy4), 1);
    chk({tag, " exec rsp_valid"}, int'(rspv4), 0);
    @(negedge clk); #1;
    chk({tag, " rsp_valid"}, int'(rspv4), 1);
    chk({tag, " id"}, int'(id4), eg);
    chk({tag, " result"}, int'(res4), er);
    chk({tag, " carry"}, int'(c4), ec);
    chk({tag, " zero"}, int'(z4), ez);
    chk({tag, " ovf"}, int'(o4), ev);
    @(negedge clk); #1;
    chk({tag, " back idle"}, int'(busy4), 0);
  endtask

  task automatic op3(input logic [2:0] mask, input string tag);
    int g, r, c, z, v;
    opc3 = 9'($urandom); a3 = 12'($urandom); b3 = 12'($urandom);
    v3 = mask; rspr3 = 1'b1;
    g = rr_pick(int'(mask), ptr3, 3);
    #1;
    chk({tag, " ready3"}, int'(rdy3), (g < 0) ? 0 : (1 << g));
    @(negedge clk); #1;
    if (g < 0) begin v3 = '0; return; end
    model_alu(int'(opc3[3*g +: 3]), int'(a3[4*g +: 4]), int'(b3[4*g +: 4]), r, c, z, v);
    ptr3 = (g + 1) % 3;
    v3 = '0;
    @(negedge clk); #1;
    chk({tag, " rsp_valid3"}, int'(rspv3), 1);
    chk({tag, " id3"}, int'(id3), g);
    chk({tag, " id3 range"}, (int'(id3) < 3) ? 1 : 0, 1);
    chk({tag, " result3"}, int'(res3), r);
    chk({tag, " carry3"}, int'(c3), c);
    @(negedge clk); #1;
  endtask

  task automatic reset4(input int cycles);
    rst4_n = 1'b0; v4 = '0; rspr4 = 1'b1;
    repeat (cycles) @(negedge clk);
    #1;
    chk("rst busy", int'(busy4), 0);
    chk("rst rsp_valid", int'(rspv4), 0);
    chk("rst id", int'(id4), 0);
    chk("rst result", int'(res4), 0);
    chk("rst flags", int'({c4, z4, o4}), 0);
    chk("rst ready", int'(rdy4), 0);
    rst4_n = 1'b1;
    ptr4 = 0;
  endtask

  typedef struct {
    int req; int opc; int a; int b; int res; int c; int z; int v;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] opcs;
    logic [15:0] as, bs;
    logic [3:0]  mask;
    int g, r, c, z, v;

    tbl[0]  = '{2, 0, 7, 9, 4'h0, 1, 1, 0};
    tbl[1]  = '{0, 1, 3, 5, 4'hE, 1, 0, 0};
    tbl[2]  = '{1, 0, 7, 1, 4'h8, 0, 0, 1};
    tbl[3]  = '{3, 1, 8, 1, 4'h7, 0, 0, 1};
    tbl[4]  = '{2, 6, 8, 1, 4'h1, 0, 0, 0};
    tbl[5]  = '{0, 7, 5, 5, 4'h1, 0, 0, 0};
    tbl[6]  = '{1, 2, 5, 0, 4'hA, 0, 0, 0};
    tbl[7]  = '{3, 3, 12, 10, 4'h8, 0, 0, 0};
    tbl[8]  = '{2, 4, 12, 3, 4'hF, 0, 0, 0};
    tbl[9]  = '{0, 5, 15, 15, 4'h0, 0, 0, 0};
    tbl[10] = '{1, 1, 5, 5, 4'h0, 0, 1, 0};
    tbl[11] = '{3, 6, 1, 8, 4'h0, 0, 0, 0};

    rst3_n = 1'b0; v3 = '0; rspr3 = 1'b1; opc3 = '0; a3 = '0; b3 = '0;
    opc4 = '0; a4 = '0; b4 = '0;
    @(negedge clk);
    reset4(2);

    // Directed ALU vectors, one requester at a time, junk in other slots.
    for (int i = 0; i < 12; i++) begin
      opcs = 12'($urandom); as = 16'($urandom); bs = 16'($urandom);
      opcs[3*tbl[i].req +: 3] = 3'(tbl[i].opc);
      as[4*tbl[i].req +: 4]   = 4'(tbl[i].a);
      bs[4*tbl[i].req +: 4]   = 4'(tbl[i].b);
      op4(4'(1 << tbl[i].req), opcs, as, bs, tbl[i].req, tbl[i].res,
          tbl[i].c, tbl[i].z, tbl[i].v, $sformatf("vec%0d", i));
    end

    // All four requesters held valid: grants 0,1,2,3,0 every 3 cycles.
    reset4(1);
    begin
      int ngr, last;
      ngr = 0; last = -3;
      v4 = 4'hF; #1;
      for (int cyc = 0; cyc < 13; cyc++) begin
        if (rdy4 != 4'h0) begin
          chk("rr grant", int'(rdy4), 1 << (ngr % 4));
          chk("rr spacing", cyc - last, 3);
          last = cyc; ngr++;
        end
        @(negedge clk); #1;
      end
      chk("rr accepts", ngr, 5);
      v4 = '0;
      repeat (3) @(negedge clk);
      #1;
    end

    // Back-pressure: response held for 5 cycles, then released.
    reset4(1);
    opc4 = 12'h008; a4 = 16'h0020; b4 = 16'h0090;  // requester 1: 2 - 9
    v4 = 4'b0010; rspr4 = 1'b0; #1;
    chk("bp ready", int'(rdy4), 4'b0010);
    @(negedge clk); v4 = 4'hF;
    @(negedge clk); #1;
    model_alu(1, 2, 9, r, c, z, v);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin rspr4 = 1'b1; #1; end
      chk("bp rsp_valid", int'(rspv4), 1);
      chk("bp id", int'(id4), 1);
      chk("bp result", int'(res4), r);
      chk("bp flags", int'({c4, z4, o4}), (c << 2) | (z << 1) | v);
      chk("bp ready0", int'(rdy4), 0);
      chk("bp busy", int'(busy4), 1);
      @(negedge clk); #1;
    end
    chk("bp idle busy", int'(busy4), 0);
    chk("bp idle rsp_valid", int'(rspv4), 0);
    chk("bp next grant", int'(rdy4), 4'b0100);
    v4 = '0;
    ptr4 = 2;

    // Reset during EXEC drops the operation and rewinds the pointer.
    v4 = 4'hF; opc4 = '0; #1;
    chk("rx grant", int'(rdy4), 4'b0100);
    @(negedge clk);
    rst4_n = 1'b0; #1;
    @(negedge clk); #1;
    chk("rx busy", int'(busy4), 0);
    chk("rx rsp_valid", int'(rspv4), 0);
    chk("rx result", int'(res4), 0);
    chk("rx ready in reset", int'(rdy4), 0);
    rst4_n = 1'b1; #1;
    chk("rx grant after", int'(rdy4), 4'b0001);
    v4 = '0;
    reset4(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(0, 15));
      opcs = 12'($urandom); as = 16'($urandom); bs = 16'($urandom);
      g = rr_pick(int'(mask), ptr4, 4);
      r = 0; c = 0; z = 0; v = 0;
      if (g >= 0)
        model_alu(int'(opcs[3*g +: 3]), int'(as[4*g +: 4]), int'(bs[4*g +: 4]), r, c, z, v);
      op4(mask, opcs, as, bs, g, r, c, z, v, $sformatf("rnd%0d", i));
    end

    // NUM_REQ = 3: wrap through ptr=0 and no out-of-range ids.
    rst3_n = 1'b0;
    @(negedge clk); #1;
    chk("r3 rst busy", int'(busy3), 0);
    rst3_n = 1'b1; ptr3 = 0;
    op3(3'b100, "n3 req2");
    chk("n3 ptr wrap", ptr3, 0);
    op3(3'b010, "n3 req1");
    for (int i = 0; i < 20; i++)
      op3(3'($urandom_range(0, 7)), $sformatf("n3 rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
